// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM sequencer and the main control FSM:
// widths, sequencer state encoding and the LM/SM opcode mapping.
package lm_sm_sequencer_pkg;

    localparam int ADDR_W = 16;
    localparam int NREG   = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    localparam logic IS_STORE_LM = 1'b0;
    localparam logic IS_STORE_SM = 1'b1;

    function automatic logic opc_is_store(input logic [3:0] opc);
        return (opc == OPC_SM) ? IS_STORE_SM : IS_STORE_LM;
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Request, memory-handshake and status bundle between the control FSM,
// memory and the LM/SM sequencer.
interface lm_sm_sequencer_if;
    import lm_sm_sequencer_pkg::*;

    logic              start;
    logic              is_store;
    logic [NREG-1:0]   mask;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_ack;
    logic [SEL_W-1:0]  reg_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_we;
    logic              rf_we;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] end_addr;

    modport master (
        output start, is_store, mask, base_addr, mem_ack,
        input  reg_sel, mem_addr, mem_req, mem_we,
        input  rf_we, busy, done, end_addr
    );

    modport slave (
        input  start, is_store, mask, base_addr, mem_ack,
        output reg_sel, mem_addr, mem_req, mem_we,
        output rf_we, busy, done, end_addr
    );

endinterface

// File: rtl/lm_sm_sequencer_penc.sv
// Lowest-set-bit priority encoder over an 8-bit register mask.
module lsb_priority_encoder8 (
    input  logic [7:0] vec_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 3'd0;
        valid_o = |vec_i;
        // Scan downwards so the lowest set bit is the last to win
        for (int i = 7; i >= 0; i--) begin
            if (vec_i[i]) idx_o = 3'(i);
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks the register mask LSB first, issuing one
// memory access per set bit at consecutive addresses from the base.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
(
    input logic              clk,
    input logic              reset,
    lm_sm_sequencer_if.slave bus
);

    state_e            state_q;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] end_addr_q;
    logic              store_q;
    logic [SEL_W-1:0]  sel;
    logic              sel_v;
    logic              in_access;
    logic              xfer;

    lsb_priority_encoder8 u_penc (
        .vec_i   (pending_q),
        .idx_o   (sel),
        .valid_o (sel_v)
    );

    assign in_access = (state_q == ST_ACCESS);
    assign xfer      = in_access && bus.mem_ack;
    assign pending_d = pending_q & (pending_q - NREG'(1));
    assign addr_d    = addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            addr_q     <= '0;
            store_q    <= 1'b0;
            end_addr_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        pending_q <= bus.mask;
                        addr_q    <= bus.base_addr;
                        store_q   <= bus.is_store;
                        // An empty list completes at once at the base
                        if (bus.mask == '0) begin
                            end_addr_q <= bus.base_addr;
                            state_q    <= ST_DONE;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ack) begin
                        pending_q <= pending_d;
                        addr_q    <= addr_d;
                        if (pending_d == '0) begin
                            end_addr_q <= addr_d;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.reg_sel  = (in_access && sel_v) ? sel : '0;
    assign bus.mem_addr = in_access ? addr_q : '0;
    assign bus.mem_req  = in_access;
    assign bus.mem_we   = in_access && store_q;
    assign bus.rf_we    = xfer && !store_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.end_addr = end_addr_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: directed plan plus random masks.
module tb_lm_sm_sequencer;
    import lm_sm_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int sel;
        int addr;
        bit we;
    } xfer_t;

    typedef struct {
        int end_addr;
        int cyc;
    } done_t;

    xfer_t exp_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int stall_left = 0;
    bit ack_rand = 0;
    bit prev_done = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: one transfer per set bit, LSB first, consecutive addresses
    task automatic push_model(input bit st, input logic [7:0] m,
                              input logic [15:0] base, input int t,
                              input int stalls, input bit lat);
        int k;
        xfer_t x;
        done_t d;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                x.sel  = i;
                x.addr = (int'(base) + k) % 65536;
                x.we   = st;
                exp_q.push_back(x);
                k++;
            end
        end
        d.end_addr = (int'(base) + k) % 65536;
        d.cyc      = lat ? (t + k + 1 + stalls) : -1;
        done_q.push_back(d);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (bus.mem_req && stall_left > 0) begin
            bus.mem_ack = 1'b0;
            stall_left--;
        end else if (ack_rand) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
        end else begin
            bus.mem_ack = 1'b1;
        end
    end

    always @(negedge clk) begin
        xfer_t e;
        done_t d;
        if (reset) begin
            prev_done = 0;
        end else begin
            if (bus.mem_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %0h sel %0d",
                             bus.mem_addr, bus.reg_sel);
                end else begin
                    e = exp_q[0];
                    chk("reg_sel", 32'(bus.reg_sel), 32'(e.sel));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                    chk("rf_we", 32'(bus.rf_we),
                        32'(bus.mem_ack && !e.we));
                    if (bus.mem_ack) void'(exp_q.pop_front());
                end
            end else begin
                chk("rf_we_idle", 32'(bus.rf_we), 32'(0));
            end
            if (bus.done) begin
                chk("done_busy", 32'(bus.busy), 32'(1));
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got end_addr %0h",
                             bus.end_addr);
                end else begin
                    d = done_q.pop_front();
                    chk("end_addr", 32'(bus.end_addr), 32'(d.end_addr));
                    chk("xfers_left", 32'(exp_q.size()), 32'(0));
                    if (d.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(d.cyc));
                end
                done_cnt++;
            end
            if (prev_done) chk("busy_fall", 32'(bus.busy), 32'(0));
            prev_done = bus.done;
        end
    end

    task automatic wait_done(input int n0);
        for (int i = 0; i < 400 && done_cnt == n0; i++) @(posedge clk);
        if (done_cnt == n0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected one");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_seq(input bit st, input logic [7:0] m,
                           input logic [15:0] base, input bit lat,
                           input int stalls, input bit poke);
        int n0;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_store  = st;
        bus.mask      = m;
        bus.base_addr = base;
        stall_left    = stalls;
        n0            = done_cnt;
        push_model(st, m, base, cyc, stalls, lat);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.is_store  = 1'($urandom_range(0, 1));
        bus.mask      = 8'($urandom);
        bus.base_addr = 16'($urandom);
        if (poke) begin
            @(posedge clk);
            #1;
            bus.start     = 1'b1;
            bus.mask      = 8'h0F;
            bus.base_addr = 16'h5555;
            bus.is_store  = ~st;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_done(n0);
    endtask

    initial begin
        int n_ok;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_store  = 1'b0;
        bus.mask      = '0;
        bus.base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_req", 32'(bus.mem_req), 32'(0));
        chk("rst_we", 32'(bus.mem_we), 32'(0));
        chk("rst_rf_we", 32'(bus.rf_we), 32'(0));
        chk("rst_sel", 32'(bus.reg_sel), 32'(0));
        chk("rst_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_end", 32'(bus.end_addr), 32'(0));

        run_seq(1'b1, 8'hA5, 16'h0100, 1'b1, 0, 1'b0);
        run_seq(1'b0, 8'hFF, 16'hFFFE, 1'b1, 0, 1'b0);
        run_seq(1'b0, 8'h00, 16'h1234, 1'b1, 0, 1'b0);
        run_seq(1'b0, 8'h81, 16'h0300, 1'b1, 3, 1'b0);
        run_seq(1'b0, 8'hFF, 16'h0700, 1'b1, 0, 1'b1);

        // Reset in the middle of an SM burst, after two transfers
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_store  = 1'b1;
        bus.mask      = 8'hFF;
        bus.base_addr = 16'h2000;
        push_model(1'b1, 8'hFF, 16'h2000, cyc, 0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_ok = 0;
        for (int i = 0; i < 50 && exp_q.size() > 6; i++) @(negedge clk);
        if (exp_q.size() > 6) begin
            checks++;
            errors++;
            $display("FAIL acks_before_reset: got %0d left expected 6",
                     exp_q.size());
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        done_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'(0));
        chk("mid_rst_req", 32'(bus.mem_req), 32'(0));
        chk("mid_rst_end", 32'(bus.end_addr), 32'(0));
        chk("mid_rst_done", 32'(bus.done), 32'(0));
        run_seq(1'b1, 8'h02, 16'h0040, 1'b1, 0, 1'b0);

        ack_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_seq(1'($urandom_range(0, 1)), 8'($urandom),
                    16'($urandom), 1'b0, 0, 1'b0);
        end
        ack_rand = 1'b0;
        repeat (2) @(posedge clk);
        chk("final_exp_q", 32'(exp_q.size()), 32'(0));
        chk("final_done_q", 32'(done_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
